// File: rtl/music_seq_ctrl_if.sv
// Signal bundle between the key/button front end and the note sequencer.
// master = front end / datapath side, slave = music_seq_ctrl.
interface music_seq_ctrl_if;
  logic       key_valid;
  logic       rec_start;
  logic       play_start;
  logic       stop;
  logic       ld_note;
  logic       ld_play;
  logic [3:0] note_counter;
  logic [3:0] notes_stored;
  logic       recording;
  logic       playing;
  logic       mute;

  modport master (
    output key_valid, rec_start, play_start, stop,
    input  ld_note, ld_play, note_counter, notes_stored, recording, playing, mute
  );

  modport slave (
    input  key_valid, rec_start, play_start, stop,
    output ld_note, ld_play, note_counter, notes_stored, recording, playing, mute
  );
endinterface

// File: rtl/music_seq_ctrl.sv
// Record/playback sequencer for the note-memory datapath.
// Optional macro LOOP_PLAY_EN: playback wraps back to note 1 instead of ending.
module music_seq_ctrl #(
  parameter int TICKS_PER_NOTE = 12500000,
  parameter int GAP_TICKS      = 1250000,
  parameter int CNT_W          = 24
) (
  input logic               clk,
  input logic               reset,
  music_seq_ctrl_if.slave   bus
);

  typedef enum logic [2:0] {IDLE, REC_WAIT, REC_HOLD, PLAY_NOTE, PLAY_GAP} state_t;

  localparam logic [CNT_W-1:0] NOTE_LAST = CNT_W'(TICKS_PER_NOTE - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);
  localparam logic [3:0]       MAX_NOTES = 4'd15;

  state_t           state, state_nx;
  logic [CNT_W-1:0] tick, tick_nx;
  logic [3:0]       note_nx, stored_nx;
  logic             ld_note_nx;
  logic             end_of_note;

  // NOTE: every comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_nx    = state;
    tick_nx     = tick;
    note_nx     = bus.note_counter;
    stored_nx   = bus.notes_stored;
    ld_note_nx  = 1'b0;
    end_of_note = 1'b0;

    case (state)
      IDLE: begin
        if (bus.rec_start) begin
          state_nx  = REC_WAIT;
          stored_nx = 4'd0;
        end else if (bus.play_start && bus.notes_stored != 4'd0) begin
          state_nx = PLAY_NOTE;
          note_nx  = 4'd1;
          tick_nx  = '0;
        end
      end

      REC_WAIT: begin
        if (bus.stop) begin
          state_nx = IDLE;
        end else if (bus.key_valid) begin
          state_nx = REC_HOLD;
          // Saturate at 15 so the datapath's pre-incremented address never wraps to 0.
          if (bus.notes_stored != MAX_NOTES) begin
            ld_note_nx = 1'b1;
            stored_nx  = bus.notes_stored + 4'd1;
          end
        end
      end

      REC_HOLD: begin
        if (bus.stop)            state_nx = IDLE;
        else if (!bus.key_valid) state_nx = REC_WAIT;
      end

      PLAY_NOTE: begin
        if (bus.stop) begin
          state_nx = IDLE;
          note_nx  = 4'd0;
          tick_nx  = '0;
        end else if (tick == NOTE_LAST) begin
          tick_nx = '0;
          if (GAP_TICKS == 0) end_of_note = 1'b1;
          else                state_nx    = PLAY_GAP;
        end else begin
          tick_nx = tick + 1'b1;
        end
      end

      PLAY_GAP: begin
        if (bus.stop) begin
          state_nx = IDLE;
          note_nx  = 4'd0;
          tick_nx  = '0;
        end else if (tick == GAP_LAST) begin
          tick_nx     = '0;
          end_of_note = 1'b1;
        end else begin
          tick_nx = tick + 1'b1;
        end
      end

      default: state_nx = IDLE;
    endcase

    if (end_of_note) begin
      if (bus.note_counter == bus.notes_stored) begin
`ifdef LOOP_PLAY_EN
        state_nx = PLAY_NOTE;
        note_nx  = 4'd1;
`else
        state_nx = IDLE;
        note_nx  = 4'd0;
`endif
      end else begin
        state_nx = PLAY_NOTE;
        note_nx  = bus.note_counter + 4'd1;
      end
    end
  end

  // Status outputs are registered from the next state so they line up with it exactly.
  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      tick             <= '0;
      bus.ld_note      <= 1'b0;
      bus.ld_play      <= 1'b0;
      bus.note_counter <= 4'd0;
      bus.notes_stored <= 4'd0;
      bus.recording    <= 1'b0;
      bus.playing      <= 1'b0;
      bus.mute         <= 1'b1;
    end else begin
      state            <= state_nx;
      tick             <= tick_nx;
      bus.ld_note      <= ld_note_nx;
      bus.note_counter <= note_nx;
      bus.notes_stored <= stored_nx;
      bus.ld_play      <= (state_nx == PLAY_NOTE) || (state_nx == PLAY_GAP);
      bus.playing      <= (state_nx == PLAY_NOTE) || (state_nx == PLAY_GAP);
      bus.recording    <= (state_nx == REC_WAIT)  || (state_nx == REC_HOLD);
      bus.mute         <= (state_nx != PLAY_NOTE);
    end
  end

endmodule

// File: tb/tb_music_seq_ctrl.sv
// Directed bench for music_seq_ctrl with TICKS_PER_NOTE = 4, GAP_TICKS = 2.
// Inputs change and outputs are sampled on the falling edge.
module tb_music_seq_ctrl;
  localparam int T = 4;
  localparam int G = 2;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_pass = 0;

  int   pulse_cnt = 0;
  int   dbl_cnt = 0;
  int   both_cnt = 0;
  logic prev_ld_note = 1'b0;

  music_seq_ctrl_if bus ();

  music_seq_ctrl #(.TICKS_PER_NOTE(T), .GAP_TICKS(G), .CNT_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Watch the write strobe for pulse count, back-to-back pulses and overlap with ld_play.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.ld_note) pulse_cnt++;
      if (bus.ld_note && prev_ld_note) dbl_cnt++;
      if (bus.ld_note && bus.ld_play) both_cnt++;
      prev_ld_note = bus.ld_note;
    end else begin
      prev_ld_note = 1'b0;
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // which: 0 rec_start, 1 play_start, 2 stop, 3 rec_start+play_start
  task automatic pulse(input int which);
    @(negedge clk);
    bus.rec_start  = (which == 0 || which == 3);
    bus.play_start = (which == 1 || which == 3);
    bus.stop       = (which == 2);
    @(negedge clk);
    bus.rec_start  = 1'b0;
    bus.play_start = 1'b0;
    bus.stop       = 1'b0;
  endtask

  task automatic press(input int n_high, input int n_low);
    @(negedge clk);
    bus.key_valid = 1'b1;
    repeat (n_high) @(negedge clk);
    bus.key_valid = 1'b0;
    repeat (n_low - 1) @(negedge clk);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_ld_play"}, int'(bus.ld_play), 0);
    check({tag, "_note"}, int'(bus.note_counter), 0);
    check({tag, "_mute"}, int'(bus.mute), 1);
    check({tag, "_playing"}, int'(bus.playing), 0);
    check({tag, "_recording"}, int'(bus.recording), 0);
  endtask

  initial begin
    int base;
    int last;
    bus.key_valid  = 1'b0;
    bus.rec_start  = 1'b0;
    bus.play_start = 1'b0;
    bus.stop       = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Reset state
    check_idle("rst");
    check("rst_ld_note", int'(bus.ld_note), 0);
    check("rst_stored", int'(bus.notes_stored), 0);

    // play_start with nothing stored is ignored
    pulse(1);
    check("empty_play_playing", int'(bus.playing), 0);
    check("empty_play_ld_play", int'(bus.ld_play), 0);
    check("empty_play_note", int'(bus.note_counter), 0);

    // Record three presses of 5, 1, 20 cycles
    base = pulse_cnt;
    pulse(0);
    check("rec_recording", int'(bus.recording), 1);
    check("rec_stored_cleared", int'(bus.notes_stored), 0);
    press(5, 3);
    pulse(1);
    check("rec_play_ignored", int'(bus.playing), 0);
    press(1, 3);
    press(20, 3);
    check("rec3_pulses", pulse_cnt - base, 3);
    check("rec3_stored", int'(bus.notes_stored), 3);
    check("rec3_still_recording", int'(bus.recording), 1);
    pulse(2);
    check("rec3_stop_recording", int'(bus.recording), 0);
    check("rec3_stop_stored", int'(bus.notes_stored), 3);

    // Full playback of 3 notes; rec_start mid-play must be ignored
    last = 18;
`ifdef LOOP_PLAY_EN
    last = 36;
`endif
    pulse(1);
    for (int i = 0; i < last; i++) begin
      check($sformatf("play_c%0d_note", i), int'(bus.note_counter), ((i % 18) / 6) + 1);
      check($sformatf("play_c%0d_mute", i), int'(bus.mute), ((i % 6) >= T) ? 1 : 0);
      check($sformatf("play_c%0d_ld_play", i), int'(bus.ld_play), 1);
      check($sformatf("play_c%0d_recording", i), int'(bus.recording), 0);
      bus.rec_start = (i == 2);
      @(negedge clk);
    end
    bus.rec_start = 1'b0;
`ifdef LOOP_PLAY_EN
    check("loop_wrap_note", int'(bus.note_counter), 1);
    check("loop_wrap_ld_play", int'(bus.ld_play), 1);
    pulse(2);
`endif
    check_idle("play_end");
    check("play_end_stored", int'(bus.notes_stored), 3);

    // stop on the second cycle of note 2
    pulse(1);
    repeat (7) @(negedge clk);
    check("stop_pre_note", int'(bus.note_counter), 2);
    check("stop_pre_mute", int'(bus.mute), 0);
    bus.stop = 1'b1;
    @(negedge clk);
    bus.stop = 1'b0;
    check_idle("stop_mid");

    // rec_start and play_start together: record wins
    pulse(3);
    check("both_recording", int'(bus.recording), 1);
    check("both_playing", int'(bus.playing), 0);
    check("both_stored", int'(bus.notes_stored), 0);

    // Record cap: 17 presses, only 15 writes
    base = pulse_cnt;
    for (int i = 0; i < 17; i++) press(2, 2);
    check("cap_pulses", pulse_cnt - base, 15);
    check("cap_stored", int'(bus.notes_stored), 15);
    pulse(2);
    check("cap_stop_recording", int'(bus.recording), 0);
    check("cap_stop_stored", int'(bus.notes_stored), 15);

    // Asynchronous reset mid-PLAY_NOTE
    pulse(1);
    @(negedge clk);
    check("arst_pre_playing", int'(bus.playing), 1);
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    check_idle("arst_async");
    check("arst_async_stored", int'(bus.notes_stored), 0);
    check("arst_async_ld_note", int'(bus.ld_note), 0);
    @(negedge clk);
    reset = 1'b0;
    pulse(1);
    check_idle("arst_after");

    check("ld_note_double", dbl_cnt, 0);
    check("ld_note_with_ld_play", both_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
